vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Parametrised VGA timing generator and pixel pipeline, successor to the fixed 640x480 VGA output stage. It owns free-running horizontal/vertical counters, emits pixel-fetch requests with coordinates to the frame-buffer read port, and realigns returned pixel data with programmable-polarity sync pulses so RGB and sync leave the block on the same cycle. It sits between the video memory read port and the board VGA pins, clocked by the 25 MHz pixel clock.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (cycles)
- H_SYNC, 96, horizontal sync width (cycles)
- H_BP, 48, horizontal back porch (cycles)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, hsync active level (0 = active-low)
- VS_POL, 0, vsync active level
- DATA_W, 12, RGB pixel width
- RD_LAT, 2, frame-buffer read latency in cycles, legal 0..4

Ports:
- clk_25MHz  in  1  pixel clock
- rst  in  1  reset; one clock, reset is synchronous and active-low
- pix_req  out  1  pixel fetch strobe for (pix_x, pix_y)
- pix_x  out  CX = $clog2(H_ACTIVE)  fetch column
- pix_y  out  CY = $clog2(V_ACTIVE)  fetch row
- pix_data  in  DATA_W  pixel returned exactly RD_LAT cycles after pix_req
- vga_rgb  out  DATA_W  pixel to DAC, zero outside active area
- vga_hsync  out  1  horizontal sync
- vga_vsync  out  1  vertical sync
- frame_start  out  1  one-cycle frame pulse (see Configuration)
- vblank  out  1  vertical blanking flag (see Configuration)

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- h_cnt counts 0..H_TOTAL-1, wraps to 0; v_cnt increments on h_cnt wrap, counts 0..V_TOTAL-1, wraps to 0 when both at terminal values.
- Stage 0 (counters): active = h_cnt < H_ACTIVE && v_cnt < V_ACTIVE; hs_raw = h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] (656..751); vs_raw = v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] (490..491).
- Stage 1 (registered): pix_req = active; pix_x/pix_y = h_cnt/v_cnt truncated to CX/CY bits, zero when not active.
- Delay line of RD_LAT registers carries active, hs_raw, vs_raw behind pix_req.
- Output stage (registered): vga_rgb = delayed active ? pix_data : 0; vga_hsync = hs_raw_d ? HS_POL : ~HS_POL; same for vsync with VS_POL.
- Counter arithmetic unsigned, widths $clog2(H_TOTAL) / $clog2(V_TOTAL); no overflow beyond terminal values.
- pix_data sampled only when delayed active is 1; any value ignored otherwise.

## Timing
- Reset (rst=0 at a clock edge): h_cnt=v_cnt=0, all delay stages cleared; pix_req=0, pix_x=pix_y=0, vga_rgb=0, vga_hsync=~HS_POL, vga_vsync=~VS_POL, frame_start=0, vblank=0. Applies mid-frame immediately; no partial line completes.
- First cycle with rst=1: h_cnt=0,v_cnt=0 evaluated; pix_req=1 for (0,0) on following edge.
- Latency: counter value at cycle t -> pix_req at t+1 -> pix_data at t+1+RD_LAT -> vga_rgb/hsync/vsync at t+2+RD_LAT. Sync and RGB always mutually aligned.
- Line period exactly H_TOTAL cycles; frame exactly H_TOTAL*V_TOTAL cycles (420000).
- pix_req high for exactly H_ACTIVE consecutive cycles per active line, never during vertical blanking.

## Configuration
- VGA_FRAME_IRQ_EN defined: frame_start pulses high for one cycle aligned with the output stage of pixel (0,0) (each frame, including the first after reset); vblank is high, aligned to outputs, while delayed v_cnt >= V_ACTIVE.
- Not defined: frame_start and vblank tied to 0, no associated registers built; all other behaviour identical.

## Test plan
- Reset: hold rst=0 5 cycles -> vga_rgb=0, vga_hsync=1, vga_vsync=1, pix_req=0; release -> first pix_req with pix_x=0,pix_y=0 one cycle later.
- Hsync: defaults -> vga_hsync low for 96 cycles, falling edges 800 cycles apart, first fall at output cycle of h_cnt=656 (656+1+RD_LAT+1 cycles after release).
- Vsync: vga_vsync low for 1600 cycles (lines 490-491), falling edges 420000 cycles apart.
- Data alignment RD_LAT=2: model returns pix_data = {pix_y[3:0],pix_x[7:0]} 2 cycles after req -> vga_rgb equals value for (x,y) 4 cycles after counter, 0 on every blanked cycle.
- Mid-frame reset at v_cnt=200,h_cnt=300 -> next cycle outputs at reset values; frame restarts at (0,0), full 420000-cycle frame follows.
- VGA_FRAME_IRQ_EN defined -> frame_start exactly one pulse per 420000 cycles, coincident with first nonzero-allowed vga_rgb; vblank high 45*800=36000 cycles per frame; undefined -> both constant 0.

Source files
------------

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA timing generator and pixel pipeline.
// Free-running h/v counters issue pixel fetches (pix_req, pix_x, pix_y);
// returned pix_data is realigned with the sync pulses so RGB and sync
// leave on the same cycle.
// Ports: clk_25MHz, rst (sync, active-low), pix_req/pix_x/pix_y (fetch),
// pix_data (read data, RD_LAT cycles after pix_req), vga_rgb,
// vga_hsync, vga_vsync, frame_start, vblank.
// Optional: VGA_FRAME_IRQ_EN builds frame_start/vblank; otherwise both 0.
module vga_timing_gen #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   DATA_W   = 12,
  parameter int   RD_LAT   = 2
) (
  input  logic                        clk_25MHz,
  input  logic                        rst,
  output logic                        pix_req,
  output logic [$clog2(H_ACTIVE)-1:0] pix_x,
  output logic [$clog2(V_ACTIVE)-1:0] pix_y,
  input  logic [DATA_W-1:0]           pix_data,
  output logic [DATA_W-1:0]           vga_rgb,
  output logic                        vga_hsync,
  output logic                        vga_vsync,
  output logic                        frame_start,
  output logic                        vblank
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int CX = $clog2(H_ACTIVE);
  localparam int CY = $clog2(V_ACTIVE);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

  // Bit positions of the per-pixel flags carried down the pipeline.
  localparam int ACT = 0;
  localparam int HS  = 1;
  localparam int VS  = 2;
`ifdef VGA_FRAME_IRQ_EN
  localparam int VB  = 3;
  localparam int FS  = 4;
  localparam int PW  = 5;
`else
  localparam int PW  = 3;
`endif

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          h_last;
  logic          v_last;

  assign h_last = (h_cnt == H_LAST);
  assign v_last = (v_cnt == V_LAST);

  always_ff @(posedge clk_25MHz) begin
    if (!rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_last) begin
      h_cnt <= '0;
      v_cnt <= v_last ? '0 : v_cnt + VW'(1);
    end else begin
      h_cnt <= h_cnt + HW'(1);
    end
  end

  logic [PW-1:0] raw;

  always_comb begin
    raw      = '0;
    raw[ACT] = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    raw[HS]  = (h_cnt >= HS_BEG) && (h_cnt <= HS_END);
    raw[VS]  = (v_cnt >= VS_BEG) && (v_cnt <= VS_END);
`ifdef VGA_FRAME_IRQ_EN
    raw[VB]  = (v_cnt >= V_ACT);
    raw[FS]  = (h_cnt == '0) && (v_cnt == '0);
`endif
  end

  logic [PW-1:0] s1;

  assign pix_req = s1[ACT];

  always_ff @(posedge clk_25MHz) begin
    if (!rst) begin
      s1    <= '0;
      pix_x <= '0;
      pix_y <= '0;
    end else begin
      s1    <= raw;
      pix_x <= raw[ACT] ? h_cnt[CX-1:0] : '0;
      pix_y <= raw[ACT] ? v_cnt[CY-1:0] : '0;
    end
  end

  // Flags wait here until the matching pix_data arrives.
  logic [PW-1:0] tl;

  generate
    if (RD_LAT == 0) begin : g_nodly
      assign tl = s1;
    end else begin : g_dly
      logic [PW-1:0] dl [RD_LAT];

      always_ff @(posedge clk_25MHz) begin
        if (!rst) begin
          for (int i = 0; i < RD_LAT; i++) dl[i] <= '0;
        end else begin
          dl[0] <= s1;
          for (int i = 1; i < RD_LAT; i++) dl[i] <= dl[i-1];
        end
      end

      assign tl = dl[RD_LAT-1];
    end
  endgenerate

  always_ff @(posedge clk_25MHz) begin
    if (!rst) begin
      vga_rgb   <= '0;
      vga_hsync <= ~HS_POL;
      vga_vsync <= ~VS_POL;
    end else begin
      vga_rgb   <= tl[ACT] ? pix_data : '0;
      vga_hsync <= tl[HS] ? HS_POL : ~HS_POL;
      vga_vsync <= tl[VS] ? VS_POL : ~VS_POL;
    end
  end

`ifdef VGA_FRAME_IRQ_EN
  always_ff @(posedge clk_25MHz) begin
    if (!rst) begin
      frame_start <= 1'b0;
      vblank      <= 1'b0;
    end else begin
      frame_start <= tl[FS];
      vblank      <= tl[VB];
    end
  end
`else
  assign frame_start = 1'b0;
  assign vblank      = 1'b0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks of vga_timing_gen, one default
// 640x480 instance and one tiny 8x4 instance for whole-frame behaviour.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   vectors;
  int   miscompares;

  always #20 clk = ~clk;

  // cyc = edges since reset release
  always @(posedge clk) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  logic        req_a;
  logic [9:0]  x_a;
  logic [8:0]  y_a;
  logic [11:0] data_a;
  logic [11:0] rgb_a;
  logic        hs_a, vs_a, fs_a, vb_a;

  vga_timing_gen u_dut (
    .clk_25MHz   (clk),
    .rst         (rst),
    .pix_req     (req_a),
    .pix_x       (x_a),
    .pix_y       (y_a),
    .pix_data    (data_a),
    .vga_rgb     (rgb_a),
    .vga_hsync   (hs_a),
    .vga_vsync   (vs_a),
    .frame_start (fs_a),
    .vblank      (vb_a)
  );

  logic       req_b;
  logic [2:0] x_b;
  logic [1:0] y_b;
  logic [7:0] data_b;
  logic [7:0] rgb_b;
  logic       hs_b, vs_b, fs_b, vb_b;

  vga_timing_gen #(
    .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (3),
    .V_ACTIVE (4), .V_FP (1), .V_SYNC (2), .V_BP (1),
    .HS_POL   (1'b1), .VS_POL (1'b0),
    .DATA_W   (8), .RD_LAT (1)
  ) u_small (
    .clk_25MHz   (clk),
    .rst         (rst),
    .pix_req     (req_b),
    .pix_x       (x_b),
    .pix_y       (y_b),
    .pix_data    (data_b),
    .vga_rgb     (rgb_b),
    .vga_hsync   (hs_b),
    .vga_vsync   (vs_b),
    .frame_start (fs_b),
    .vblank      (vb_b)
  );

  // Frame-buffer models; junk is returned when no fetch is pending.
  logic [11:0] a1, a2;
  logic        av1, av2;
  logic [7:0]  b1;
  logic        bv1;

  always @(posedge clk) begin
    av1 <= req_a;
    a1  <= {y_a[3:0], x_a[7:0]};
    av2 <= av1;
    a2  <= a1;
    bv1 <= req_b;
    b1  <= {3'b101, y_b, x_b};
  end

  assign data_a = av2 ? a2 : 12'hABC;
  assign data_b = bv1 ? b1 : 8'hFF;

  // Default instance: output at edge k shows counter t = k-4.
  function automatic logic exp_hs_a(int k);
    int t, h;
    t = k - 4;
    if (t < 0) return 1'b1;
    h = t % 800;
    return !(h >= 656 && h <= 751);
  endfunction

  function automatic logic [11:0] exp_rgb_a(int k);
    int t, h, v;
    t = k - 4;
    if (t < 0) return 12'h000;
    h = t % 800;
    v = (t / 800) % 525;
    if (h < 640 && v < 480) return {v[3:0], h[7:0]};
    return 12'h000;
  endfunction

  function automatic logic [19:0] exp_req_a(int k);
    int t, h, v;
    t = k - 1;
    h = t % 800;
    v = (t / 800) % 525;
    if (h < 640 && v < 480) return {1'b1, h[9:0], v[8:0]};
    return 20'h0;
  endfunction

  function automatic logic [1:0] exp_irq_a(int k);
    logic [1:0] r;
    r = 2'b00;
`ifdef VGA_FRAME_IRQ_EN
    r[1] = (k - 4) == 0;
`endif
    return r;
  endfunction

  // Small instance: {fs, vb, vs, hs, rgb}, output shows t = k-3.
  function automatic logic [11:0] exp_b(int k);
    int t, h, v;
    logic [7:0] rgb;
    logic fs, vb, vs, hs;
    t = k - 3;
    if (t < 0) return 12'b0010_0000_0000;
    h = t % 16;
    v = (t / 16) % 8;
    rgb = (h < 8 && v < 4) ? {3'b101, v[1:0], h[2:0]} : 8'h00;
    hs = (h >= 10 && h <= 12);
    vs = !(v == 5 || v == 6);
    fs = 1'b0;
    vb = 1'b0;
`ifdef VGA_FRAME_IRQ_EN
    fs = (h == 0 && v == 0);
    vb = (v >= 4);
`endif
    return {fs, vb, vs, hs, rgb};
  endfunction

  function automatic logic [5:0] exp_req_b(int k);
    int t, h, v;
    t = k - 1;
    h = t % 16;
    v = (t / 16) % 8;
    if (h < 8 && v < 4) return {1'b1, h[2:0], v[1:0]};
    return 6'h0;
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({rgb_a, hs_a, vs_a, req_a, fs_a, vb_a}
        !== {12'h000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_a: got rgb=%h hs=%b vs=%b req=%b fs=%b vb=%b expected 000 1 1 0 0 0",
               rgb_a, hs_a, vs_a, req_a, fs_a, vb_a);
    end
    vectors++;
    if ({rgb_b, hs_b, vs_b, req_b, x_b, y_b}
        !== {8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 2'd0}) begin
      miscompares++;
      $display("FAIL reset_b: got rgb=%h hs=%b vs=%b req=%b expected 00 0 1 0",
               rgb_b, hs_b, vs_b, req_b);
    end
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if ({req_a, x_a, y_a} !== {1'b1, 10'd0, 9'd0}) begin
      miscompares++;
      $display("FAIL first_req: got req=%b x=%0d y=%0d expected 1 0 0",
               req_a, x_a, y_a);
    end
    @(negedge clk);
    vectors++;
    if ({req_a, x_a, y_a} !== {1'b1, 10'd1, 9'd0}) begin
      miscompares++;
      $display("FAIL second_req: got req=%b x=%0d y=%0d expected 1 1 0",
               req_a, x_a, y_a);
    end
  endtask

  task automatic test_hsync();
    int   falls[$];
    logic prev;
    logic e;
    prev = hs_a;
    while (cyc < 2400) begin
      @(negedge clk);
      e = exp_hs_a(cyc);
      vectors++;
      if ({hs_a, vs_a} !== {e, 1'b1}) begin
        miscompares++;
        $display("FAIL hsync k=%0d: got hs=%b vs=%b expected hs=%b vs=1",
                 cyc, hs_a, vs_a, e);
      end
      vectors++;
      if ({fs_a, vb_a} !== exp_irq_a(cyc)) begin
        miscompares++;
        $display("FAIL irq_a k=%0d: got %b%b expected %b",
                 cyc, fs_a, vb_a, exp_irq_a(cyc));
      end
      if (prev === 1'b1 && hs_a === 1'b0) falls.push_back(cyc);
      prev = hs_a;
    end
    vectors++;
    if (falls.size() != 3 || falls[0] != 660
        || falls[1] != 1460 || falls[2] != 2260) begin
      miscompares++;
      $display("FAIL hsync_falls: got count=%0d first=%0d expected 3 at 660/1460/2260",
               falls.size(), (falls.size() > 0) ? falls[0] : -1);
    end
  endtask

  task automatic test_data();
    repeat (1700) begin
      @(negedge clk);
      vectors++;
      if (rgb_a !== exp_rgb_a(cyc)) begin
        miscompares++;
        $display("FAIL rgb_a k=%0d: got %h expected %h",
                 cyc, rgb_a, exp_rgb_a(cyc));
      end
      vectors++;
      if ({req_a, x_a, y_a} !== exp_req_a(cyc)) begin
        miscompares++;
        $display("FAIL req_a k=%0d: got %h expected %h",
                 cyc, {req_a, x_a, y_a}, exp_req_a(cyc));
      end
    end
  endtask

  task automatic test_small_frame();
    repeat (260) begin
      @(negedge clk);
      vectors++;
      if ({fs_b, vb_b, vs_b, hs_b, rgb_b} !== exp_b(cyc)) begin
        miscompares++;
        $display("FAIL out_b k=%0d: got %h expected %h",
                 cyc, {fs_b, vb_b, vs_b, hs_b, rgb_b}, exp_b(cyc));
      end
      vectors++;
      if ({req_b, x_b, y_b} !== exp_req_b(cyc)) begin
        miscompares++;
        $display("FAIL req_b k=%0d: got %h expected %h",
                 cyc, {req_b, x_b, y_b}, exp_req_b(cyc));
      end
    end
  endtask

  task automatic test_mid_reset();
    int   n;
    int   falls[$];
    logic prev;
    n = 0;
    // small counter after edge k is k mod 128; 37 = line 2, column 5
    while ((cyc % 128) != 37 && n < 200) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if ((cyc % 128) != 37) begin
      miscompares++;
      $display("FAIL mid_wait: got phase %0d expected 37", cyc % 128);
    end
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if ({req_b, x_b, y_b, rgb_b, hs_b, vs_b, fs_b, vb_b}
        !== {6'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL mid_reset_b: got req=%b rgb=%h hs=%b vs=%b expected 0 00 0 1",
               req_b, rgb_b, hs_b, vs_b);
    end
    vectors++;
    if ({req_a, rgb_a, hs_a, vs_a} !== {1'b0, 12'h000, 1'b1, 1'b1}) begin
      miscompares++;
      $display("FAIL mid_reset_a: got req=%b rgb=%h hs=%b vs=%b expected 0 000 1 1",
               req_a, rgb_a, hs_a, vs_a);
    end
    rst = 1'b1;
    prev = vs_b;
    repeat (300) begin
      @(negedge clk);
      vectors++;
      if ({fs_b, vb_b, vs_b, hs_b, rgb_b} !== exp_b(cyc)) begin
        miscompares++;
        $display("FAIL restart_b k=%0d: got %h expected %h",
                 cyc, {fs_b, vb_b, vs_b, hs_b, rgb_b}, exp_b(cyc));
      end
      vectors++;
      if ({req_b, x_b, y_b} !== exp_req_b(cyc)) begin
        miscompares++;
        $display("FAIL restart_req k=%0d: got %h expected %h",
                 cyc, {req_b, x_b, y_b}, exp_req_b(cyc));
      end
      if (prev === 1'b1 && vs_b === 1'b0) falls.push_back(cyc);
      prev = vs_b;
    end
    vectors++;
    if (falls.size() != 2 || falls[0] != 83 || falls[1] != 211) begin
      miscompares++;
      $display("FAIL vsync_falls: got count=%0d first=%0d expected 2 at 83/211",
               falls.size(), (falls.size() > 0) ? falls[0] : -1);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b0;
    test_reset();
    test_hsync();
    test_data();
    test_small_frame();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
